// File: rtl/cordic_rotate_scheduler_if.sv
// Requester/result bundle for the shared CORDIC rotation scheduler.
// The scheduler takes the slave view; requesters and result consumers take the master view.
interface cordic_rotate_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [13*NUM_REQ-1:0] req_angle;
   logic [12*NUM_REQ-1:0] req_x;
   logic [12*NUM_REQ-1:0] req_y;
   logic                  res_valid;
   logic [ID_W-1:0]       res_id;
   logic [9:0]            res_x;
   logic [9:0]            res_y;

   modport master (
      output req_valid, req_angle, req_x, req_y,
      input  req_ready, res_valid, res_id, res_x, res_y
   );

   modport slave (
      input  req_valid, req_angle, req_x, req_y,
      output req_ready, res_valid, res_id, res_x, res_y
   );
endinterface

// File: rtl/cordic_rotate_scheduler.sv
// Round-robin scheduler sharing one pipelined CORDIC rotation core between NUM_REQ requesters.
// Each issue carries a tag through a pipeline matched to the core so results return with their requester id.
module cordic_rotate_scheduler #(
   parameter int NUM_REQ        = 4,
   parameter int ID_W           = 2,
   parameter int CORDIC_LATENCY = 3
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   cordic_rotate_scheduler_if.slave bus,
   output logic [12:0] core_a,
   output logic [11:0] core_x,
   output logic [11:0] core_y,
   output logic        core_areset,
   input  logic [9:0]  core_xo,
   input  logic [9:0]  core_yo,
   output logic        busy
);
   // Stage 0 lines up with the registered core operands; the remaining stages span the core latency.
   localparam int TAG_N = CORDIC_LATENCY + 1;

   logic [12:0] angle_arr [NUM_REQ];
   logic [11:0] x_arr     [NUM_REQ];
   logic [11:0] y_arr     [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign angle_arr[g] = bus.req_angle[13*g +: 13];
      assign x_arr[g]     = bus.req_x[12*g +: 12];
      assign y_arr[g]     = bus.req_y[12*g +: 12];
   end

   logic [ID_W-1:0]            ptr_q, ptr_d;
   logic [ID_W-1:0]            cand, grant_id;
   logic                       found, xfer;
   logic [12:0]                core_a_q, core_a_d;
   logic [11:0]                core_x_q, core_x_d;
   logic [11:0]                core_y_q, core_y_d;
   logic                       core_areset_q, core_areset_d;
   logic [TAG_N-1:0]           tag_v_q, tag_v_d;
   logic [TAG_N-1:0][ID_W-1:0] tag_id_q, tag_id_d;
   logic                       res_valid_q, res_valid_d;
   logic [ID_W-1:0]            res_id_q, res_id_d;
   logic [9:0]                 res_x_q, res_x_d;
   logic [9:0]                 res_y_q, res_y_d;

   always_comb begin
      found    = 1'b0;
      grant_id = ptr_q;
      cand     = ptr_q;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         cand = (cand == ID_W'(NUM_REQ - 1)) ? '0 : cand + ID_W'(1);
         if (!found && bus.req_valid[cand]) begin
            found    = 1'b1;
            grant_id = cand;
         end
      end
      xfer          = found && !reset;
      bus.req_ready = '0;
      if (xfer) bus.req_ready[grant_id] = 1'b1;
   end

   always_comb begin
      ptr_d         = ptr_q;
      core_a_d      = core_a_q;
      core_x_d      = core_x_q;
      core_y_d      = core_y_q;
      core_areset_d = reset;
      tag_v_d       = {tag_v_q[TAG_N-2:0], xfer};
      tag_id_d      = {tag_id_q[TAG_N-2:0], (xfer ? grant_id : '0)};
      res_valid_d   = tag_v_q[TAG_N-1];
      res_id_d      = res_id_q;
      res_x_d       = res_x_q;
      res_y_d       = res_y_q;
      if (xfer) begin
         ptr_d    = grant_id;
         core_a_d = angle_arr[grant_id];
         core_x_d = x_arr[grant_id];
         core_y_d = y_arr[grant_id];
      end
      if (tag_v_q[TAG_N-1]) begin
         res_id_d = tag_id_q[TAG_N-1];
         res_x_d  = core_xo;
         res_y_d  = core_yo;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      core_areset_q <= core_areset_d;
      if (reset) begin
         ptr_q       <= ID_W'(NUM_REQ - 1);
         core_a_q    <= '0;
         core_x_q    <= '0;
         core_y_q    <= '0;
         tag_v_q     <= '0;
         tag_id_q    <= '0;
         res_valid_q <= 1'b0;
         res_id_q    <= '0;
         res_x_q     <= '0;
         res_y_q     <= '0;
      end else begin
         ptr_q       <= ptr_d;
         core_a_q    <= core_a_d;
         core_x_q    <= core_x_d;
         core_y_q    <= core_y_d;
         tag_v_q     <= tag_v_d;
         tag_id_q    <= tag_id_d;
         res_valid_q <= res_valid_d;
         res_id_q    <= res_id_d;
         res_x_q     <= res_x_d;
         res_y_q     <= res_y_d;
      end
   end

   assign core_a        = core_a_q;
   assign core_x        = core_x_q;
   assign core_y        = core_y_q;
   assign core_areset   = core_areset_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_id    = res_id_q;
   assign bus.res_x     = res_x_q;
   assign bus.res_y     = res_y_q;
   assign busy          = (|tag_v_q) | res_valid_q;
endmodule

// File: tb/tb_cordic_rotate_scheduler.sv
// Directed bench for cordic_rotate_scheduler with a 3-cycle core stand-in (xo = x[11:2], yo = y[11:2]).
module tb_cordic_rotate_scheduler;
   logic        CLOCK_50 = 1'b0;
   logic        reset;
   logic [12:0] core_a;
   logic [11:0] core_x, core_y;
   logic        core_areset;
   logic [9:0]  core_xo, core_yo;
   logic        busy;

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;

   logic [12:0] angle_tab [4];
   logic [11:0] x_tab     [4];
   logic [11:0] y_tab     [4];
   logic [11:0] px [3];
   logic [11:0] py [3];

   cordic_rotate_scheduler_if #(.NUM_REQ(4), .ID_W(2)) bus ();

   cordic_rotate_scheduler #(
      .NUM_REQ(4),
      .ID_W(2),
      .CORDIC_LATENCY(3)
   ) dut (
      .CLOCK_50(CLOCK_50),
      .reset(reset),
      .bus(bus),
      .core_a(core_a),
      .core_x(core_x),
      .core_y(core_y),
      .core_areset(core_areset),
      .core_xo(core_xo),
      .core_yo(core_yo),
      .busy(busy)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) begin
      px[0] <= core_x;
      px[1] <= px[0];
      px[2] <= px[1];
      py[0] <= core_y;
      py[1] <= py[0];
      py[2] <= py[1];
   end
   assign core_xo = px[2][11:2];
   assign core_yo = py[2][11:2];

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic drive_ops();
      bus.req_angle = {angle_tab[3], angle_tab[2], angle_tab[1], angle_tab[0]};
      bus.req_x     = {x_tab[3], x_tab[2], x_tab[1], x_tab[0]};
      bus.req_y     = {y_tab[3], y_tab[2], y_tab[1], y_tab[0]};
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int cnt;
      int id;
      reset         = 1'b1;
      bus.req_valid = 4'hF;
      angle_tab = '{13'h100, 13'h101, 13'h102, 13'h103};
      x_tab     = '{12'h104, 12'h208, 12'h30C, 12'h410};
      y_tab     = '{12'h7FC, 12'h800, 12'h044, 12'hFF8};
      drive_ops();

      tick();
      tick();
      chk("rst_ready", 32'(bus.req_ready), 0);
      chk("rst_core_a", 32'(core_a), 0);
      chk("rst_core_x", 32'(core_x), 0);
      chk("rst_core_y", 32'(core_y), 0);
      chk("rst_res_valid", 32'(bus.res_valid), 0);
      chk("rst_res_id", 32'(bus.res_id), 0);
      chk("rst_res_x", 32'(bus.res_x), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_areset_hi", 32'(core_areset), 1);
      bus.req_valid = 4'h0;
      reset         = 1'b0;
      tick();
      chk("areset_drop", 32'(core_areset), 0);

      // All four requesters held for 8 cycles; results overlap with issue from k=5.
      for (int k = 0; k < 13; k++) begin
         bus.req_valid = (k < 8) ? 4'hF : 4'h0;
         #1;
         chk("rr_grant", 32'(bus.req_ready), (k < 8) ? (1 << (k % 4)) : 0);
         if (k >= 5) begin
            id = (k - 5) % 4;
            chk("rr_res_valid", 32'(bus.res_valid), 1);
            chk("rr_res_id", 32'(bus.res_id), id);
            chk("rr_res_x", 32'(bus.res_x), 32'(x_tab[id][11:2]));
            chk("rr_res_y", 32'(bus.res_y), 32'(y_tab[id][11:2]));
         end else begin
            chk("rr_res_idle", 32'(bus.res_valid), 0);
         end
         tick();
      end
      chk("rr_drain_valid", 32'(bus.res_valid), 0);
      chk("rr_drain_busy", 32'(busy), 0);

      // Single request from requester 2.
      angle_tab[2] = 13'h0324;
      x_tab[2]     = 12'h200;
      y_tab[2]     = 12'h100;
      drive_ops();
      bus.req_valid = 4'b0100;
      #1;
      chk("one_ready", 32'(bus.req_ready), 32'h4);
      tick();
      bus.req_valid = 4'h0;
      chk("one_core_a", 32'(core_a), 32'h0324);
      chk("one_core_x", 32'(core_x), 32'h200);
      chk("one_core_y", 32'(core_y), 32'h100);
      chk("one_busy", 32'(busy), 1);
      for (int j = 0; j < 3; j++) begin
         tick();
         chk("one_early", 32'(bus.res_valid), 0);
      end
      tick();
      chk("one_res_valid", 32'(bus.res_valid), 1);
      chk("one_res_id", 32'(bus.res_id), 2);
      chk("one_res_x", 32'(bus.res_x), 32'h080);
      chk("one_res_y", 32'(bus.res_y), 32'h040);
      tick();
      chk("one_pulse_end", 32'(bus.res_valid), 0);
      chk("one_busy_low", 32'(busy), 0);
      chk("one_res_x_hold", 32'(bus.res_x), 32'h080);

      // Pointer to 1, idle cycle, then requesters 1 and 3 contend.
      bus.req_valid = 4'b0010;
      #1;
      chk("p1_grant", 32'(bus.req_ready), 32'h2);
      tick();
      bus.req_valid = 4'b0000;
      #1;
      chk("drop_ready", 32'(bus.req_ready), 0);
      tick();
      bus.req_valid = 4'b1010;
      #1;
      chk("pair_first", 32'(bus.req_ready), 32'h8);
      tick();
      #1;
      chk("pair_second", 32'(bus.req_ready), 32'h2);
      tick();
      bus.req_valid = 4'b0000;
      cnt = 0;
      for (int j = 0; j < 8; j++) begin
         tick();
         if (bus.res_valid) cnt++;
      end
      chk("pair_results", 32'(cnt), 3);
      chk("pair_busy", 32'(busy), 0);

      // Three issues from pointer=1 (order 2,0,1), then reset two cycles later.
      bus.req_valid = 4'b0111;
      #1;
      chk("mid_grant0", 32'(bus.req_ready), 32'h4);
      tick();
      chk("mid_grant1", 32'(bus.req_ready), 32'h1);
      tick();
      chk("mid_grant2", 32'(bus.req_ready), 32'h2);
      tick();
      bus.req_valid = 4'h0;
      tick();
      reset         = 1'b1;
      bus.req_valid = 4'hF;
      #1;
      chk("mid_rst_ready", 32'(bus.req_ready), 0);
      tick();
      chk("mid_rst_res_valid", 32'(bus.res_valid), 0);
      chk("mid_rst_areset", 32'(core_areset), 1);
      chk("mid_rst_core_a", 32'(core_a), 0);
      chk("mid_rst_res_id", 32'(bus.res_id), 0);
      chk("mid_rst_res_x", 32'(bus.res_x), 0);
      chk("mid_rst_res_y", 32'(bus.res_y), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      tick();
      reset         = 1'b0;
      bus.req_valid = 4'h0;
      cnt = 0;
      for (int j = 0; j < 6; j++) begin
         tick();
         if (bus.res_valid) cnt++;
      end
      chk("mid_no_results", 32'(cnt), 0);
      bus.req_valid = 4'hF;
      #1;
      chk("post_rst_grant", 32'(bus.req_ready), 32'h1);
      tick();
      bus.req_valid = 4'h0;
      for (int j = 0; j < 4; j++) tick();
      chk("post_res_valid", 32'(bus.res_valid), 1);
      chk("post_res_id", 32'(bus.res_id), 0);
      chk("post_res_x", 32'(bus.res_x), 32'h041);
      tick();

      // Twenty idle cycles: everything quiet, core operands held.
      for (int j = 0; j < 20; j++) begin
         chk("idle_ready", 32'(bus.req_ready), 0);
         chk("idle_res_valid", 32'(bus.res_valid), 0);
         chk("idle_busy", 32'(busy), 0);
         tick();
      end
      chk("idle_core_a", 32'(core_a), 32'h100);
      chk("idle_core_x", 32'(core_x), 32'h104);
      chk("idle_core_y", 32'(core_y), 32'h7FC);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
